// File: rtl/zbtram_burst.sv
// zbtram_burst: behavioural ZBT synchronous SRAM with flow-through or pipelined
// reads, byte write enables, chip enable, linear wrapping bursts and
// write-to-read forwarding for the single read/write overlap the ZBT timing allows.
module zbtram_burst #(
   parameter int ADDR_W     = 13,
   parameter int DEPTH      = 5120,
   parameter int DATA_W     = 8,
   parameter int NB         = DATA_W / 8,
   parameter int LATENCY    = 1,
   parameter int BURST_BITS = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce_n,
   input  logic              adv_ld_n,
   input  logic              we_n,
   input  logic [NB-1:0]     bw_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid
);

   // Elaboration-time sanity checks on the parameter set.
   if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
      $error("zbtram_burst: LATENCY must be 1 (flow-through) or 2 (pipelined)");
   end
   if (DATA_W % 8 != 0 || NB * 8 != DATA_W) begin : g_bad_width
      $error("zbtram_burst: DATA_W must be a multiple of 8 and NB must equal DATA_W/8");
   end
   if (BURST_BITS < 1 || BURST_BITS >= ADDR_W || ADDR_W >= 32) begin : g_bad_burst
      $error("zbtram_burst: need 1 <= BURST_BITS < ADDR_W < 32");
   end

   // One issued operation as it travels down the pipeline.
   typedef struct packed {
      logic              valid;
      logic              we;
      logic [ADDR_W-1:0] addr;
   } cmd_t;

   // Addresses at or above DEPTH do not exist: writes vanish, reads give zero.
   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return 32'(a) < 32'(DEPTH);
   endfunction

   // NOTE: the storage array has no reset; contents survive rst like a real SRAM,
   // and leaving it out of the reset keeps it mappable onto block RAM.
   logic [DATA_W-1:0] mem [DEPTH];

   // Burst state: counter holds the address of the most recent operation.
   logic [ADDR_W-1:0]     cnt;
   logic                  active;
   logic                  op_we;
   logic [BURST_BITS-1:0] low_next;
   logic [ADDR_W-1:0]     next_addr;

   cmd_t cmd;      // operation commanded at this edge
   cmd_t pipe1;    // operation commanded one edge ago
   cmd_t rd_cmd;   // operation whose array read happens at this edge
   cmd_t wr_cmd;   // operation whose write data is sampled at this edge

   logic              rd_en;
   logic              wr_en;
   logic              fwd;
   logic [DATA_W-1:0] rd_word;

   // Decode the pins plus burst state into the operation issued at this edge.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path through the if/else leaves it unassigned (which would infer a latch).
      cmd       = '0;
      low_next  = cnt[BURST_BITS-1:0] + BURST_BITS'(1);
      next_addr = {cnt[ADDR_W-1:BURST_BITS], low_next};
      if (!ce_n) begin
         if (!adv_ld_n) begin
            cmd.valid = 1'b1;
            cmd.we    = ~we_n;
            cmd.addr  = addr;
         end else if (active) begin
            cmd.valid = 1'b1;
            cmd.we    = op_we;
            cmd.addr  = next_addr;
         end
      end
   end

   // Burst counter and op latch: load on adv_ld_n=0, wrap-increment on continue.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         cnt    <= '0;
         active <= 1'b0;
         op_we  <= 1'b0;
      end else if (ce_n) begin
         active <= 1'b0;
      end else if (!adv_ld_n) begin
         cnt    <= addr;
         op_we  <= ~we_n;
         active <= 1'b1;
      end else if (active) begin
         cnt    <= next_addr;
      end
   end

   // First pipeline stage; reset turns anything in flight into a NOP.
   always_ff @(posedge clk) begin
      if (rst) pipe1 <= '0;
      else     pipe1 <= cmd;
   end

   if (LATENCY == 1) begin : g_flow
      // Flow-through: read the array at the command edge, write data one edge later.
      assign rd_cmd = cmd;
      assign wr_cmd = pipe1;
   end else begin : g_pipe
      cmd_t pipe2;
      // Second stage holds writes until their data edge two cycles after command.
      always_ff @(posedge clk) begin
         if (rst) pipe2 <= '0;
         else     pipe2 <= pipe1;
      end
      assign rd_cmd = pipe1;
      assign wr_cmd = pipe2;
   end

   // The write commanded one cycle before a read lands on the read's edge;
   // every older write is already in the array.
   assign rd_en = rd_cmd.valid && !rd_cmd.we;
   assign wr_en = wr_cmd.valid && wr_cmd.we && in_range(wr_cmd.addr) && !rst;
   assign fwd   = wr_cmd.valid && wr_cmd.we && (wr_cmd.addr == rd_cmd.addr);

   // Read word: array contents with lanes of a coinciding write patched in.
   always_comb begin
      rd_word = '0;
      if (in_range(rd_cmd.addr)) begin
         rd_word = mem[rd_cmd.addr];
         if (fwd) begin
            for (int i = 0; i < NB; i++) begin
               if (!bw_n[i]) rd_word[i*8 +: 8] = wdata[i*8 +: 8];
            end
         end
      end
   end

   // Byte-lane write into the array at the write's data edge.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < NB; i++) begin
            if (!bw_n[i]) mem[wr_cmd.addr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   // Registered read port: rdata holds between reads, valid marks read cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata       <= '0;
         rdata_valid <= 1'b0;
      end else if (rd_en) begin
         rdata       <= rd_word;
         rdata_valid <= 1'b1;
      end else begin
         rdata_valid <= 1'b0;
      end
   end

endmodule
